// File: rtl/key_access_arbiter.sv
// Two-requester key storage access arbiter: round-robin grant, privilege/lock policy, key strobes.
// Optional KEY_RDATA_SCRUB_EN: clears rdata_o on the edge after the RESP cycle of a read.
module key_access_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_i,
   input  logic [1:0]  we_i,
   input  logic [1:0]  priv_i,
   input  logic [31:0] wdata0_i,
   input  logic [31:0] wdata1_i,
   input  logic        lock_i,
   input  logic [31:0] key_rdata_i,
   output logic [1:0]  gnt_o,
   output logic [1:0]  done_o,
   output logic [1:0]  err_o,
   output logic [31:0] rdata_o,
   output logic        key_we_o,
   output logic        key_re_o,
   output logic [31:0] key_wdata_o,
   output logic        locked_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

   state_t      r_state, w_next;
   logic        r_win, r_we, r_ok, r_last, r_locked;
   logic [31:0] r_wdata, r_rdata;

   logic        w_accept, w_win, w_we, w_ok;

   // Winner selection and policy, only meaningful while IDLE
   always_comb begin
      w_accept = (r_state == IDLE) && (|req_i);
      case (req_i)
         2'b01:   w_win = 1'b0;
         2'b10:   w_win = 1'b1;
         2'b11:   w_win = ~r_last;
         default: w_win = 1'b0;
      endcase
      w_we = we_i[w_win];
      w_ok = priv_i[w_win] && (!w_we || !r_locked);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      gnt_o       = 2'b00;
      done_o      = 2'b00;
      err_o       = 2'b00;
      key_we_o    = 1'b0;
      key_re_o    = 1'b0;
      key_wdata_o = 32'h0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = w_ok ? ACCESS : RESP;
         end
         ACCESS: begin
            gnt_o[r_win] = 1'b1;
            key_we_o     = r_we;
            key_re_o     = ~r_we;
            if (r_we) key_wdata_o = r_wdata;
            w_next       = r_we ? RESP : RDWAIT;
         end
         RDWAIT: begin
            gnt_o[r_win] = 1'b1;
            w_next       = RESP;
         end
         RESP: begin
            gnt_o[r_win] = 1'b1;
            if (r_ok) done_o[r_win] = 1'b1;
            else      err_o[r_win]  = 1'b1;
            w_next       = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // r_last resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win   <= 1'b0;
         r_we    <= 1'b0;
         r_ok    <= 1'b0;
         r_last  <= 1'b1;
         r_wdata <= 32'h0;
      end else if (w_accept) begin
         r_win   <= w_win;
         r_we    <= w_we;
         r_ok    <= w_ok;
         r_last  <= w_win;
         r_wdata <= w_win ? wdata1_i : wdata0_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_locked <= 1'b0;
      else if (lock_i) r_locked <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 32'h0;
      end else if (r_state == RDWAIT) begin
         r_rdata <= key_rdata_i;
`ifdef KEY_RDATA_SCRUB_EN
      end else if (r_state == RESP && r_ok && !r_we) begin
         r_rdata <= 32'h0;
`endif
      end
   end

   assign rdata_o  = r_rdata;
   assign locked_o = r_locked;

endmodule

// File: tb/tb_key_access_arbiter.sv
// Randomized self-checking bench for key_access_arbiter against a transaction-level model.
module tb_key_access_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_i, we_i, priv_i;
   logic [31:0] wdata0_i, wdata1_i, key_rdata_i;
   logic        lock_i;
   logic [1:0]  gnt_o, done_o, err_o;
   logic [31:0] rdata_o, key_wdata_o;
   logic        key_we_o, key_re_o, locked_o;

   key_access_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .priv_i(priv_i),
      .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .lock_i(lock_i),
      .key_rdata_i(key_rdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
      .rdata_o(rdata_o), .key_we_o(key_we_o), .key_re_o(key_re_o),
      .key_wdata_o(key_wdata_o), .locked_o(locked_o)
   );

   always #5 clk = ~clk;

`ifdef KEY_RDATA_SCRUB_EN
   localparam bit SCRUB = 1'b1;
`else
   localparam bit SCRUB = 1'b0;
`endif

   int n_chk = 0;
   int n_err = 0;

   // Model state: who was served last, lock status, visible read data
   int          last_m;
   bit          locked_m;
   logic [31:0] rdata_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      last_m   = 1;
      locked_m = 1'b0;
      rdata_m  = 32'h0;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
   task automatic do_txn(input logic [1:0] req, input logic [1:0] we, input logic [1:0] priv,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] rd);
      int w, lat;
      bit ok, isw, acc;
      logic [1:0] oh;
      req_i = req; we_i = we; priv_i = priv; wdata0_i = w0; wdata1_i = w1;
      if (req == 2'b11) w = (last_m == 0) ? 1 : 0;
      else              w = req[1] ? 1 : 0;
      isw = we[w];
      ok  = priv[w] && (!isw || !locked_m);
      lat = !ok ? 1 : (isw ? 2 : 3);
      oh  = (w == 1) ? 2'b10 : 2'b01;
      last_m = w;
      for (int k = 1; k <= lat + 1; k++) begin
         @(posedge clk);
         @(negedge clk);
         acc = ok && (k == 1);
         check("gnt", gnt_o, (k <= lat) ? oh : 2'b00);
         check("key_we", key_we_o, acc && isw);
         check("key_re", key_re_o, acc && !isw);
         check("key_wdata", key_wdata_o, (acc && isw) ? ((w == 1) ? w1 : w0) : 32'h0);
         if (ok && !isw && k == lat) rdata_m = rd;
         if (SCRUB && ok && !isw && k == lat + 1) rdata_m = 32'h0;
         check("done", done_o, (k == lat && ok) ? oh : 2'b00);
         check("err", err_o, (k == lat && !ok) ? oh : 2'b00);
         check("rdata", rdata_o, rdata_m);
         check("locked", locked_o, locked_m);
         key_rdata_i = (ok && !isw && k == 2) ? rd : $urandom;
      end
   endtask

   task automatic do_lock();
      req_i  = 2'b00;
      lock_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lock_i   = 1'b0;
      locked_m = 1'b1;
      check("lock_set", locked_o, 1'b1);
      check("lock_gnt", gnt_o, 2'b00);
   endtask

   task automatic do_reset();
      req_i = 2'b00;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_gnt", gnt_o, 2'b00);
      check("rst_done", done_o, 2'b00);
      check("rst_err", err_o, 2'b00);
      check("rst_locked", locked_o, 1'b0);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_strobe", {key_we_o, key_re_o}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req_i = 2'b00; we_i = 2'b00; priv_i = 2'b00;
      wdata0_i = 32'h0; wdata1_i = 32'h0; lock_i = 1'b0; key_rdata_i = 32'h0;
      model_reset();
      @(negedge clk);
      do_reset();
      @(negedge clk);

      // Privileged write by requester 0, then privileged read by requester 1
      do_txn(2'b01, 2'b01, 2'b01, 32'hA5A5_1234, 32'h0, 32'h0);
      do_txn(2'b10, 2'b00, 2'b10, 32'h0, 32'h0, 32'hDEAD_BEEF);

      // Both held: grants must alternate
      for (int i = 0; i < 4; i++)
         do_txn(2'b11, 2'b11, 2'b11, $urandom, $urandom, $urandom);

      // Reset in the middle of an ACCESS cycle
      req_i = 2'b01; we_i = 2'b01; priv_i = 2'b01; wdata0_i = 32'h1357_9BDF;
      @(posedge clk);
      @(negedge clk);
      check("mid_we_pre", key_we_o, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_we", key_we_o, 1'b0);
      check("mid_gnt", gnt_o, 2'b00);
      check("mid_locked", locked_o, 1'b0);
      check("mid_wdata", key_wdata_o, 32'h0);
      req_i = 2'b00;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_nodone", {done_o, err_o}, 4'h0);
      do_txn(2'b01, 2'b01, 2'b01, 32'h2468_ACE0, 32'h0, 32'h0);

      // Lock blocks writes but privileged reads still work; unprivileged read denied
      do_txn(2'b10, 2'b00, 2'b10, 32'h0, 32'h0, 32'hCAFE_F00D);
      do_lock();
      do_txn(2'b01, 2'b01, 2'b01, 32'hA5A5_1234, 32'h0, 32'h0);
      do_txn(2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h1111_2222);
      do_txn(2'b10, 2'b00, 2'b10, 32'h0, 32'h0, 32'h3333_4444);

      // Random traffic with occasional lock, reset and idle gaps
      do_reset();
      for (int i = 0; i < 300; i++) begin
         int r;
         logic [1:0] rq, pv;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_reset();
         end else if (r < 4) begin
            do_lock();
         end else if (r < 8) begin
            req_i = 2'b00;
            @(negedge clk);
            check("idle_gnt", gnt_o, 2'b00);
         end else begin
            rq = 2'($urandom_range(1, 3));
            pv = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            do_txn(rq, 2'($urandom), pv, $urandom, $urandom, $urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
